// File: rtl/reg_status_file.sv
// rtl/reg_status_file.sv - architectural register file with per-register rename status (busy + ROB tag)
// Optional same-cycle commit forwarding on the read ports is enabled by defining REG_BYPASS_EN.
module reg_status_file #(
    parameter int ROB_WIDTH = 4,
    parameter int REG_NUM   = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 commit_en,
    input  logic [4:0]           commit_rd,
    input  logic [31:0]          commit_wdata,
    input  logic [ROB_WIDTH-1:0] commit_tag,
    input  logic                 issue_en,
    input  logic [4:0]           issue_rd,
    input  logic [ROB_WIDTH-1:0] issue_tag,
    input  logic [4:0]           rs1_idx,
    output logic                 rs1_busy,
    output logic [ROB_WIDTH-1:0] rs1_tag,
    output logic [31:0]          rs1_val,
    input  logic [4:0]           rs2_idx,
    output logic                 rs2_busy,
    output logic [ROB_WIDTH-1:0] rs2_tag,
    output logic [31:0]          rs2_val
);

    logic [31:0]          regs_q [REG_NUM];
    logic [31:0]          regs_d [REG_NUM];
    logic [REG_NUM-1:0]   busy_q;
    logic [REG_NUM-1:0]   busy_d;
    logic [ROB_WIDTH-1:0] tag_q  [REG_NUM];
    logic [ROB_WIDTH-1:0] tag_d  [REG_NUM];

    logic commit_live;
    logic issue_live;

    assign commit_live = rdy_in && commit_en && (commit_rd != 5'd0);
    assign issue_live  = rdy_in && issue_en && !clear && (issue_rd != 5'd0);

    // Issue is applied after commit so a same-register rename in the same cycle wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (commit_live) begin
            regs_d[commit_rd] = commit_wdata;
            if (busy_q[commit_rd] && (tag_q[commit_rd] == commit_tag)) begin
                busy_d[commit_rd] = 1'b0;
            end
        end
        if (rdy_in && clear) begin
            busy_d = '0;
        end
        if (issue_live) begin
            busy_d[issue_rd] = 1'b1;
            tag_d[issue_rd]  = issue_tag;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    function automatic logic [ROB_WIDTH+32:0] read_port(input logic [4:0] idx);
        logic                 busy;
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          val;
        busy = busy_q[idx];
        tag  = tag_q[idx];
        val  = regs_q[idx];
`ifdef REG_BYPASS_EN
        // Forward the retiring value; the entry stays busy only if a younger rename holds it.
        if (commit_live && (commit_rd == idx)) begin
            val  = commit_wdata;
            busy = busy_q[idx] && (tag_q[idx] != commit_tag);
        end
`endif
        if (idx == 5'd0) begin
            busy = 1'b0;
            tag  = '0;
            val  = '0;
        end
        return {busy, tag, val};
    endfunction

    always_comb begin
        {rs1_busy, rs1_tag, rs1_val} = read_port(rs1_idx);
        {rs2_busy, rs2_tag, rs2_val} = read_port(rs2_idx);
    end

endmodule

// File: tb/tb_reg_status_file.sv
// tb/tb_reg_status_file.sv - directed and randomized checks of reg_status_file against a reference model
module tb_reg_status_file;

    localparam int RW = 4;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          rdy_in = 1'b1;
    logic          clear = 1'b0;
    logic          commit_en = 1'b0;
    logic [4:0]    commit_rd = '0;
    logic [31:0]   commit_wdata = '0;
    logic [RW-1:0] commit_tag = '0;
    logic          issue_en = 1'b0;
    logic [4:0]    issue_rd = '0;
    logic [RW-1:0] issue_tag = '0;
    logic [4:0]    rs1_idx = '0;
    logic          rs1_busy;
    logic [RW-1:0] rs1_tag;
    logic [31:0]   rs1_val;
    logic [4:0]    rs2_idx = '0;
    logic          rs2_busy;
    logic [RW-1:0] rs2_tag;
    logic [31:0]   rs2_val;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0]   m_val  [32];
    logic          m_busy [32];
    logic [RW-1:0] m_tag  [32];

    reg_status_file #(.ROB_WIDTH(RW), .REG_NUM(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .commit_en(commit_en), .commit_rd(commit_rd), .commit_wdata(commit_wdata),
        .commit_tag(commit_tag), .issue_en(issue_en), .issue_rd(issue_rd),
        .issue_tag(issue_tag), .rs1_idx(rs1_idx), .rs1_busy(rs1_busy),
        .rs1_tag(rs1_tag), .rs1_val(rs1_val), .rs2_idx(rs2_idx),
        .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_val(rs2_val)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
        end
    endtask

    task automatic model_update();
        if (!rdy_in) return;
        if (commit_en && commit_rd != 0) begin
            m_val[commit_rd] = commit_wdata;
            if (m_busy[commit_rd] && m_tag[commit_rd] == commit_tag) m_busy[commit_rd] = 1'b0;
        end
        if (clear) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else if (issue_en && issue_rd != 0) begin
            m_busy[issue_rd] = 1'b1;
            m_tag[issue_rd]  = issue_tag;
        end
    endtask

    task automatic model_read(input logic [4:0] idx, output logic b, output logic [RW-1:0] t,
                              output logic [31:0] v);
        b = m_busy[idx]; t = m_tag[idx]; v = m_val[idx];
`ifdef REG_BYPASS_EN
        if (rdy_in && commit_en && commit_rd == idx) begin
            v = commit_wdata;
            b = m_busy[idx] && (m_tag[idx] != commit_tag);
        end
`endif
        if (idx == 0) begin
            b = 1'b0; t = '0; v = '0;
        end
    endtask

    task automatic check_ports(input string nm);
        logic b; logic [RW-1:0] t; logic [31:0] v;
        model_read(rs1_idx, b, t, v);
        check({nm, "_rs1_busy"}, 64'(rs1_busy), 64'(b));
        check({nm, "_rs1_val"}, 64'(rs1_val), 64'(v));
        if (b || rs1_idx == 0) check({nm, "_rs1_tag"}, 64'(rs1_tag), 64'(t));
        model_read(rs2_idx, b, t, v);
        check({nm, "_rs2_busy"}, 64'(rs2_busy), 64'(b));
        check({nm, "_rs2_val"}, 64'(rs2_val), 64'(v));
        if (b || rs2_idx == 0) check({nm, "_rs2_tag"}, 64'(rs2_tag), 64'(t));
    endtask

    task automatic idle();
        rdy_in = 1'b1; clear = 1'b0; commit_en = 1'b0; issue_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_update();
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [RW-1:0] t);
        idle(); issue_en = 1'b1; issue_rd = rd; issue_tag = t; tick(); idle();
    endtask

    task automatic commit(input logic [4:0] rd, input logic [RW-1:0] t, input logic [31:0] d);
        idle(); commit_en = 1'b1; commit_rd = rd; commit_tag = t; commit_wdata = d;
    endtask

    task automatic read1(input logic [4:0] idx);
        rs1_idx = idx; #1;
    endtask

    initial begin
        model_reset();
        #12;
        rs1_idx = 5'd3; rs2_idx = 5'd31; #1;
        check("rst_rs1_busy", 64'(rs1_busy), 64'd0);
        check("rst_rs1_val", 64'(rs1_val), 64'd0);
        check("rst_rs2_tag", 64'(rs2_tag), 64'd0);
        @(negedge clk_in); rst_in = 1'b0;

        issue(5'd3, 4'd2);
        read1(5'd3);
        check("t2_busy", 64'(rs1_busy), 64'd1);
        check("t2_tag", 64'(rs1_tag), 64'd2);
        commit(5'd3, 4'd2, 32'hDEADBEEF);
        read1(5'd3);
`ifdef REG_BYPASS_EN
        check("t2_byp_busy", 64'(rs1_busy), 64'd0);
        check("t2_byp_val", 64'(rs1_val), 64'hDEADBEEF);
`else
        check("t2_nobyp_busy", 64'(rs1_busy), 64'd1);
`endif
        tick(); idle(); read1(5'd3);
        check("t2_commit_busy", 64'(rs1_busy), 64'd0);
        check("t2_commit_val", 64'(rs1_val), 64'hDEADBEEF);

        issue(5'd4, 4'd1);
        issue(5'd4, 4'd5);
        commit(5'd4, 4'd1, 32'd7); tick(); idle(); read1(5'd4);
        check("t3_val", 64'(rs1_val), 64'd7);
        check("t3_busy", 64'(rs1_busy), 64'd1);
        check("t3_tag", 64'(rs1_tag), 64'd5);
        commit(5'd4, 4'd5, 32'd8); tick(); idle(); read1(5'd4);
        check("t3_release", 64'(rs1_busy), 64'd0);

        commit(5'd6, 4'd3, 32'h11);
        issue_en = 1'b1; issue_rd = 5'd6; issue_tag = 4'd9;
        tick(); idle(); read1(5'd6);
        check("t4_val", 64'(rs1_val), 64'h11);
        check("t4_busy", 64'(rs1_busy), 64'd1);
        check("t4_tag", 64'(rs1_tag), 64'd9);

        issue(5'd1, 4'd1); issue(5'd2, 4'd2); issue(5'd7, 4'd7);
        commit(5'd2, 4'd2, 32'h55);
        clear = 1'b1; issue_en = 1'b1; issue_rd = 5'd8; issue_tag = 4'd4;
        tick(); idle();
        rs1_idx = 5'd1; rs2_idx = 5'd7; #1;
        check("t5_x1_busy", 64'(rs1_busy), 64'd0);
        check("t5_x7_busy", 64'(rs2_busy), 64'd0);
        rs1_idx = 5'd2; rs2_idx = 5'd8; #1;
        check("t5_x2_busy", 64'(rs1_busy), 64'd0);
        check("t5_x2_val", 64'(rs1_val), 64'h55);
        check("t5_x8_busy", 64'(rs2_busy), 64'd0);

        commit(5'd0, 4'd3, 32'hFFFFFFFF);
        issue_en = 1'b1; issue_rd = 5'd0; issue_tag = 4'd3;
        tick(); idle(); read1(5'd0);
        check("t6_x0_val", 64'(rs1_val), 64'd0);
        check("t6_x0_busy", 64'(rs1_busy), 64'd0);
        check("t6_x0_tag", 64'(rs1_tag), 64'd0);
        commit(5'd9, 4'd0, 32'h1234);
        issue_en = 1'b1; issue_rd = 5'd9; issue_tag = 4'd6; rdy_in = 1'b0;
        tick(); idle(); read1(5'd9);
        check("t6_rdy0_val", 64'(rs1_val), 64'd0);
        check("t6_rdy0_busy", 64'(rs1_busy), 64'd0);

        for (int c = 0; c < 600; c++) begin
            rdy_in    = ($urandom_range(0, 9) != 0);
            clear     = ($urandom_range(0, 19) == 0);
            commit_en = $urandom_range(0, 1);
            commit_rd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            commit_wdata = $urandom;
            commit_tag   = $urandom_range(0, 1) ? m_tag[commit_rd] : RW'($urandom);
            issue_en  = $urandom_range(0, 1);
            issue_rd  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            issue_tag = RW'($urandom);
            rs1_idx   = $urandom_range(0, 1) ? commit_rd : 5'($urandom_range(0, 31));
            rs2_idx   = 5'($urandom_range(0, 7));
            #1;
            check_ports("rnd");
            tick();
        end

        idle();
        issue(5'd5, 4'd6);
        rs1_idx = 5'd5; rs2_idx = 5'd6; #1;
        check("t1_pre_busy", 64'(rs1_busy), 64'd1);
        rst_in = 1'b1; #1;
        check("t1_x5_busy", 64'(rs1_busy), 64'd0);
        check("t1_x5_val", 64'(rs1_val), 64'd0);
        check("t1_x5_tag", 64'(rs1_tag), 64'd0);
        check("t1_x6_val", 64'(rs2_val), 64'd0);
        check("t1_x6_busy", 64'(rs2_busy), 64'd0);
        model_reset();
        @(negedge clk_in); rst_in = 1'b0;
        issue(5'd5, 4'd3); read1(5'd5);
        check("post_rst_busy", 64'(rs1_busy), 64'd1);
        check("post_rst_tag", 64'(rs1_tag), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
